// File: rtl/bnn_param_loader_if.sv
// Byte input, neuron-chain and readback signals of the BNN parameter loader.
// The host/tile side is the master; the loader is the slave.
interface bnn_param_loader_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       chain_setup;
    logic       chain_data;
    logic       chain_tail;
    logic [7:0] rb_data;
    logic       rb_valid;

    // chain_tail belongs to the host side: it comes from the last neuron, not the loader.
    modport master (
        output start, in_data, in_valid, chain_tail,
        input  busy, done, in_ready, chain_setup, chain_data, rb_data, rb_valid
    );

    modport slave (
        input  start, in_data, in_valid, chain_tail,
        output busy, done, in_ready, chain_setup, chain_data, rb_data, rb_valid
    );
endinterface

// File: rtl/bnn_param_loader.sv
// Serialises parameter bytes MSB-first into a daisy-chain of BNN neurons and
// returns the bits shifted out of the chain tail as left-aligned readback bytes.
module bnn_param_loader #(
    parameter int NEURONS   = 4,
    parameter int INPUTS    = 8,
    parameter int BIAS_BITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bnn_param_loader_if.slave  bus
);
    localparam int CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
    localparam int CNT_W      = $clog2(CHAIN_BITS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] bits_left;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rb_sr;

    logic             busy_q;
    logic             done_q;
    logic             in_ready_q;
    logic             setup_q;
    logic             data_q;
    logic [7:0]       rb_data_q;
    logic             rb_valid_q;

    logic [7:0]       rb_next;
    logic [7:0]       rb_aligned;
    logic             last_of_chain;
    logic             byte_end;

    // NOTE: every variable written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        rb_next    = {rb_sr[6:0], bus.chain_tail};
        // A short final byte holds bit_cnt+1 bits in its low end; push them to the top.
        rb_aligned = rb_next << (3'd7 - bit_cnt);
    end

    assign last_of_chain = (bits_left == CNT_W'(1));
    assign byte_end      = (bit_cnt == 3'd7) || last_of_chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, exactly like the neurons that shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bits_left  <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rb_sr      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            setup_q    <= 1'b0;
            data_q     <= 1'b0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rb_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        bits_left  <= CNT_W'(CHAIN_BITS);
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    // The chain stays frozen here, so in_valid gaps never disturb bit order.
                    if (bus.in_valid && in_ready_q) begin
                        state      <= SHIFT;
                        tx_sr      <= bus.in_data;
                        bit_cnt    <= '0;
                        rb_sr      <= '0;
                        in_ready_q <= 1'b0;
                        setup_q    <= 1'b1;
                        data_q     <= bus.in_data[7];
                    end
                end
                SHIFT: begin
                    tx_sr     <= {tx_sr[6:0], 1'b0};
                    data_q    <= tx_sr[6];
                    rb_sr     <= rb_next;
                    bits_left <= bits_left - CNT_W'(1);
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        setup_q    <= 1'b0;
                        data_q     <= 1'b0;
                        rb_valid_q <= 1'b1;
                        rb_data_q  <= rb_aligned;
                        if (last_of_chain) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.chain_setup = setup_q;
    assign bus.chain_data  = data_q;
    assign bus.rb_data     = rb_data_q;
    assign bus.rb_valid    = rb_valid_q;
endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader with a 2-neuron (22-bit) chain model:
// table of full loads plus hand-written reset-abort and start-during-shift sequences.
module tb_bnn_param_loader;
    localparam int CHAIN_BITS = 22;

    logic clk;
    logic rst_n;
    bnn_param_loader_if bus ();

    bnn_param_loader #(.NEURONS(2), .INPUTS(8), .BIAS_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural neuron chain: shifts toward the tail while chain_setup is high.
    logic [CHAIN_BITS-1:0] chain = '0;
    assign bus.chain_tail = chain[CHAIN_BITS-1];

    int         checks = 0;
    int         failures = 0;
    int         setup_cycles = 0;
    int         done_cnt = 0;
    int         run_len = 0;
    int         bursts [$];
    logic [7:0] rb_log [$];
    int         exp_burst [3] = '{8, 8, 6};

    always @(posedge clk) begin
        if (bus.chain_setup) begin
            chain        <= {chain[CHAIN_BITS-2:0], bus.chain_data};
            setup_cycles <= setup_cycles + 1;
            run_len      <= run_len + 1;
        end else if (run_len != 0) begin
            bursts.push_back(run_len);
            run_len <= 0;
        end
        if (bus.done)     done_cnt <= done_cnt + 1;
        if (bus.rb_valid) rb_log.push_back(bus.rb_data);
    end

    typedef struct {
        logic [0:2][7:0] bytes;
        int              gap;
        bit              poke;
        logic [2:0]      n1_bias;
        logic [7:0]      n1_w;
        logic [2:0]      n0_bias;
        logic [7:0]      n0_w;
        bit              check_rb;
        logic [0:2][7:0] rb;
    } load_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {bus.busy, bus.done, bus.in_ready, bus.chain_setup, bus.chain_data,
                bus.rb_valid, bus.rb_data};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic run_load(input string tag, input load_vec_t v);
        int setup0;
        int done0;
        int n;
        setup0 = setup_cycles;
        done0  = done_cnt;
        rb_log.delete();
        bursts.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_byte(v.bytes[i]);
            if (v.poke && i == 0) begin
                @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            if (v.gap != 0 && i < 2) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                repeat (8) @(negedge clk);
                for (int g = 0; g < v.gap; g++) begin
                    check($sformatf("%s_gap_setup", tag), 32'(bus.chain_setup), 32'd0);
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (done_cnt == done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        if (v.poke) begin
            repeat (20) @(negedge clk);
            check($sformatf("%s_no_restart_busy", tag), 32'(bus.busy), 32'd0);
        end
        check($sformatf("%s_done_pulses", tag), 32'(done_cnt - done0), 32'd1);
        check($sformatf("%s_setup_cycles", tag), 32'(setup_cycles - setup0), 32'(CHAIN_BITS));
        check($sformatf("%s_idle_outs", tag), 32'({bus.busy, bus.in_ready, bus.chain_setup}), 32'd0);
        check($sformatf("%s_burst_count", tag), 32'(bursts.size()), 32'd3);
        for (int k = 0; k < 3 && k < bursts.size(); k++)
            check($sformatf("%s_burst%0d", tag, k), 32'(bursts[k]), 32'(exp_burst[k]));
        check($sformatf("%s_n1_bias", tag), 32'(chain[21:19]), 32'(v.n1_bias));
        check($sformatf("%s_n1_w", tag),    32'(chain[18:11]), 32'(v.n1_w));
        check($sformatf("%s_n0_bias", tag), 32'(chain[10:8]),  32'(v.n0_bias));
        check($sformatf("%s_n0_w", tag),    32'(chain[7:0]),   32'(v.n0_w));
        check($sformatf("%s_rb_count", tag), 32'(rb_log.size()), 32'd3);
        if (v.check_rb)
            for (int k = 0; k < 3 && k < rb_log.size(); k++)
                check($sformatf("%s_rb%0d", tag, k), 32'(rb_log[k]), 32'(v.rb[k]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    load_vec_t vecs [5];
    load_vec_t v;
    int        setup0;
    int        done0;

    initial begin
        vecs[0] = '{{8'hA5, 8'h3C, 8'hF0}, 0, 1'b0, 3'd5, 8'h29, 3'd7, 8'h3C, 1'b1, {8'h00, 8'h00, 8'h00}};
        vecs[1] = '{{8'hA5, 8'h3C, 8'hF0}, 0, 1'b0, 3'd5, 8'h29, 3'd7, 8'h3C, 1'b1, {8'hA5, 8'h3C, 8'hF0}};
        vecs[2] = '{{8'hA5, 8'h3C, 8'hF0}, 5, 1'b0, 3'd5, 8'h29, 3'd7, 8'h3C, 1'b1, {8'hA5, 8'h3C, 8'hF0}};
        vecs[3] = '{{8'hFF, 8'h00, 8'h5B}, 0, 1'b0, 3'd7, 8'hF8, 3'd0, 8'h16, 1'b1, {8'hA5, 8'h3C, 8'hF0}};
        vecs[4] = '{{8'h12, 8'h34, 8'h57}, 2, 1'b0, 3'd0, 8'h91, 3'd5, 8'h15, 1'b1, {8'hFF, 8'h00, 8'h58}};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_outs", 32'(outs()), 32'd0);

        // Reset while waiting in LOAD, then in_valid in IDLE must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("load_ready_busy", 32'({bus.busy, bus.in_ready}), 32'h3);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        setup0 = setup_cycles;
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("idle_ignore_valid%0d", c),
                  32'({bus.busy, bus.in_ready, bus.chain_setup}), 32'd0);
        end
        bus.in_valid = 1'b0;
        check("idle_no_shift", 32'(setup_cycles - setup0), 32'd0);

        for (int i = 0; i < 5; i++) run_load($sformatf("v%0d", i), vecs[i]);

        // Abort after 5 bits of the first byte.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        send_byte(8'hA5);
        repeat (5) @(posedge clk);
        #2;
        check("abort_pre_state", 32'({bus.busy, bus.chain_setup}), 32'h3);
        done0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_async_outs", 32'(outs()), 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - done0), 32'd0);
        v = '{{8'hA5, 8'h3C, 8'hF0}, 0, 1'b0, 3'd5, 8'h29, 3'd7, 8'h3C, 1'b0, {8'h00, 8'h00, 8'h00}};
        run_load("reload", v);

        // start during SHIFT is ignored; readback returns the reload contents.
        v = '{{8'hFF, 8'h00, 8'h5B}, 0, 1'b1, 3'd7, 8'hF8, 3'd0, 8'h16, 1'b1, {8'hA5, 8'h3C, 8'hF0}};
        run_load("poke", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Serial parameter transmitter for a daisy-chain of BNN neurons. Each neuron holds {bias, weights} in a shift register that shifts one bit per clk while its setup input is high.
- Accepts parameter bytes over a valid/ready byte interface and serializes them, MSB first, onto the chain head (chain_data with chain_setup).
- Captures the bits falling out of the chain tail and returns them as readback bytes, so software can verify the previous load.
- Sits between the tile's byte input pins and neuron 0 of the chain.

Parameters:
- NEURONS, 4, number of neurons in the chain.
- INPUTS, 8, weight bits per neuron.
- BIAS_BITS, 3, bias bits per neuron.
- CHAIN_BITS, NEURONS*(INPUTS+BIAS_BITS), derived localparam giving total chain length. Must be ≥1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a full chain load.
- busy  out  1  high while a load is in progress (states LOAD, SHIFT, DONE).
- done  out  1  one-cycle pulse when the load completes.
- in_data  in  8  parameter byte; first bit to send is bit 7.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte.
- chain_setup  out  1  shift enable to every neuron in the chain.
- chain_data  out  1  serial bit to the chain head (neuron 0 param_in).
- chain_tail  in  1  param_out of the last neuron.
- rb_data  out  8  readback byte, left-aligned.
- rb_valid  out  1  one-cycle strobe qualifying rb_data; no backpressure.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters and shift registers cleared. busy, done, in_ready, chain_setup, chain_data, rb_valid all 0; rb_data=0. Chain contents are not touched.
- All outputs are decoded from flops only. There is no combinational path from any input to any output.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → LOAD, and bits_left is loaded with CHAIN_BITS.
  - in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1, chain_setup=0.
  - On in_valid&in_ready: tx_sr is loaded with in_data and the bit counter is cleared → SHIFT.
- SHIFT:
  - chain_setup=1 and chain_data=tx_sr[7].
  - On each posedge: tx_sr shifts left; chain_tail is sampled into rb_sr (LSB-in, MSB-first); bits_left decrements; the bit counter increments.
  - The chain_tail value sampled is the pre-shift tail bit, because the neurons shift on the same edge.
  - Leave SHIFT when bit counter=8 or bits_left reaches 0. Go to DONE if bits_left=0, else LOAD.
- Rate: exactly one bubble cycle per byte (LOAD). With continuous in_valid, a full byte takes 9 cycles.
- Readback:
  - When 8 bits have been collected, or at the last chain bit, pulse rb_valid for one cycle (the cycle after the final sampling edge).
  - rb_data holds the collected bits left-aligned; unused low bits are 0.
- Partial final byte:
  - Only the top (CHAIN_BITS mod 8) bits of the final byte are sent; the remaining low bits are ignored.
  - Byte count per load = ceil(CHAIN_BITS/8).
- DONE: busy=1 and done=1 for exactly one cycle → IDLE.
- start while not IDLE: ignored.
- Gaps: chain_setup is held low whenever the loader waits in LOAD, so the chain freezes and bit order is preserved across in_valid gaps.
- Resulting layout: the first bit sent ends at the bias MSB of the last neuron. Each neuron's 11 bits, MSB first, are {bias, weights}.
- Reset mid-load: immediate abort to IDLE. A partially shifted chain is left as-is. The next start performs a complete fresh load.

Test Plan:
1. rst_n=0 mid-run, then released → all outputs 0, in_ready=0, state IDLE; in_valid=1 in IDLE is not accepted.
2. NEURONS=2 (CHAIN_BITS=22); start, then bytes 0xA5, 0x3C, 0xF0 with in_valid held high:
   - chain_data = 10100101 00111100 111100.
   - chain_setup bursts of 8, 8, 6 cycles with 1-cycle gaps.
   - done pulses once.
   - Final chain state: neuron1 bias=5, weights=0x29; neuron0 bias=7, weights=0x3C.
3. Repeat the load of scenario 2 → rb_data strobes 0xA5, 0x3C, 0xF0 (last byte left-aligned, low bits 0), three rb_valid pulses total.
4. in_valid deasserted for 5 cycles between every byte → chain_setup stays low during gaps; final chain state identical to scenario 2.
5. rst_n pulsed low after 5 bits of byte 0 → outputs 0 asynchronously, no done. A subsequent full load produces the correct chain state.
6. start pulsed during SHIFT → ignored: exactly one done, exactly 22 chain_setup-high cycles.
